// File: rtl/collision_ctl.sv
// Per-frame Donkey/barrel collision checker and lives keeper.
// Snapshots positions on frame_start, scans one barrel slot per clock, then resolves.
module collision_ctl #(
  parameter int BARRELS     = 10,
  parameter int DONKEY_W    = 48,
  parameter int DONKEY_H    = 64,
  parameter int BARREL_W    = 32,
  parameter int BARREL_H    = 32,
  parameter int LIVES       = 3,
  parameter int INVULN_TIME = 65_000_000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_game,
  input  logic                    animation,
  input  logic                    frame_start,
  input  logic [10:0]             xpos,
  input  logic [10:0]             ypos,
  input  logic [BARRELS-1:0]      barrel,
  input  logic [BARRELS-1:0][10:0] xpos_barrel,
  input  logic [BARRELS-1:0][10:0] ypos_barrel,
  output logic                    hit,
  output logic [3:0]              hit_idx,
  output logic [1:0]              lives,
  output logic                    invuln,
  output logic                    game_over
);
  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] WAIT_FRAME = 3'd1;
  localparam logic [2:0] SCAN       = 3'd2;
  localparam logic [2:0] RESOLVE    = 3'd3;
  localparam logic [2:0] INVULN     = 3'd4;
  localparam logic [2:0] OVER       = 3'd5;

  localparam int CW = $clog2(INVULN_TIME + 1);

  logic [2:0]                state;
  logic [CW-1:0]             cnt;
  logic [3:0]                idx, first_idx;
  logic                      any_hit;
  logic [10:0]               snap_x, snap_y;
  logic [BARRELS-1:0]        snap_act;
  logic [BARRELS-1:0][10:0]  snap_bx, snap_by;

  // 12-bit sums so boxes near the right/bottom screen edge do not wrap
  logic [11:0] x12, y12, bx12, by12;
  logic        overlap, slot_hit;

  always_comb begin
    x12      = {1'b0, snap_x};
    y12      = {1'b0, snap_y};
    bx12     = {1'b0, snap_bx[idx]};
    by12     = {1'b0, snap_by[idx]};
    overlap  = (x12 < bx12 + 12'(BARREL_W)) && (bx12 < x12 + 12'(DONKEY_W)) &&
               (y12 < by12 + 12'(BARREL_H)) && (by12 < y12 + 12'(DONKEY_H));
    slot_hit = snap_act[idx] && overlap;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      first_idx <= '0;
      any_hit   <= 1'b0;
      snap_x    <= '0;
      snap_y    <= '0;
      snap_act  <= '0;
      snap_bx   <= '0;
      snap_by   <= '0;
      hit       <= 1'b0;
      hit_idx   <= '0;
      lives     <= 2'(LIVES);
      invuln    <= 1'b0;
      game_over <= 1'b0;
    end else begin
      hit <= 1'b0;
      if (!start_game) begin
        state     <= IDLE;
        lives     <= 2'(LIVES);
        invuln    <= 1'b0;
        game_over <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            lives     <= 2'(LIVES);
            invuln    <= 1'b0;
            game_over <= 1'b0;
            state     <= WAIT_FRAME;
          end
          WAIT_FRAME: if (frame_start && !animation) begin
            snap_x   <= xpos;
            snap_y   <= ypos;
            snap_act <= barrel;
            snap_bx  <= xpos_barrel;
            snap_by  <= ypos_barrel;
            any_hit  <= 1'b0;
            idx      <= '0;
            state    <= SCAN;
          end
          SCAN: begin
            if (slot_hit) begin
              any_hit <= 1'b1;
              if (!any_hit) first_idx <= idx;
            end
            if (idx == 4'(BARRELS - 1)) state <= RESOLVE;
            else                        idx   <= idx + 4'd1;
          end
          RESOLVE: begin
            if (!any_hit) state <= WAIT_FRAME;
            else begin
              hit     <= 1'b1;
              hit_idx <= first_idx;
              lives   <= (lives != 2'd0) ? lives - 2'd1 : 2'd0;
              if (lives <= 2'd1) state <= OVER;
              else begin
                state  <= INVULN;
                cnt    <= '0;
                invuln <= 1'b1;
              end
            end
          end
          INVULN: begin
            if (cnt == CW'(INVULN_TIME - 1)) begin
              invuln <= 1'b0;
              state  <= WAIT_FRAME;
            end else cnt <= cnt + 1'b1;
          end
          OVER:    game_over <= 1'b1;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_collision_ctl.sv
// Randomized bench for collision_ctl against a box-overlap / lives model.
module tb_collision_ctl;
  localparam int NB  = 10;
  localparam int INV = 20;

  logic clk = 1'b0, rst = 1'b0;
  logic start_game = 1'b0, animation = 1'b0, frame_start = 1'b0;
  logic [10:0] xpos = '0, ypos = '0;
  logic [NB-1:0] barrel = '0;
  logic [NB-1:0][10:0] xpos_barrel = '0, ypos_barrel = '0;
  logic hit, invuln, game_over;
  logic [3:0] hit_idx;
  logic [1:0] lives;

  collision_ctl #(.BARRELS(NB), .INVULN_TIME(INV)) dut (
    .clk(clk), .rst(rst), .start_game(start_game), .animation(animation),
    .frame_start(frame_start), .xpos(xpos), .ypos(ypos), .barrel(barrel),
    .xpos_barrel(xpos_barrel), .ypos_barrel(ypos_barrel), .hit(hit),
    .hit_idx(hit_idx), .lives(lives), .invuln(invuln), .game_over(game_over));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int lives_m = 3;
  int sx, sy, smask;
  int sbx[NB], sby[NB];

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  function automatic int model_first();
    for (int i = 0; i < NB; i++)
      if (smask[i] && sx < sbx[i] + 32 && sbx[i] < sx + 48 &&
          sy < sby[i] + 32 && sby[i] < sy + 64) return i;
    return -1;
  endfunction

  function automatic int clamp(input int v);
    return (v < 0) ? 0 : (v > 2047) ? 2047 : v;
  endfunction

  task automatic clear_scene(input int x, input int y);
    sx = x; sy = y; smask = 0;
    for (int i = 0; i < NB; i++) begin sbx[i] = 0; sby[i] = 0; end
  endtask

  task automatic drive_scene();
    xpos = 11'(sx); ypos = 11'(sy); barrel = NB'(smask);
    for (int i = 0; i < NB; i++) begin
      xpos_barrel[i] = 11'(sbx[i]);
      ypos_barrel[i] = 11'(sby[i]);
    end
  endtask

  task automatic scramble();
    xpos = 11'($urandom); ypos = 11'($urandom); barrel = NB'($urandom);
    for (int i = 0; i < NB; i++) begin
      xpos_barrel[i] = 11'($urandom);
      ypos_barrel[i] = 11'($urandom);
    end
  endtask

  task automatic random_scene();
    sx = $urandom_range(0, 2047); sy = $urandom_range(0, 2047);
    smask = int'($urandom & $urandom & 32'h3ff);
    for (int i = 0; i < NB; i++) begin
      sbx[i] = clamp(sx + int'($urandom_range(0, 140)) - 60);
      sby[i] = clamp(sy + int'($urandom_range(0, 150)) - 60);
    end
  endtask

  // Called #1 after an edge with the DUT waiting for a frame
  task automatic run_scan(input bit anim);
    int exp_i, hk, hc, hc2, ic;
    bit exp_hit;
    exp_i   = anim ? -1 : model_first();
    exp_hit = (exp_i >= 0);
    drive_scene();
    animation = anim; frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    scramble();
    if (!anim) animation = 1'($urandom_range(0, 1));
    hc = 0; hk = 0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (hit) begin hc++; hk = k; end
      if (k == 11) begin
        if (exp_hit) begin
          lives_m--;
          chk("hit_idx", hit_idx, exp_i);
        end
        chk("lives", lives, lives_m);
        chk("invuln_rise", invuln, int'(exp_hit && lives_m != 0));
        chk("game_over_early", game_over, 0);
      end
    end
    animation = 1'b0;
    chk("hit_count", hc, int'(exp_hit));
    if (exp_hit) chk("hit_cycle", hk, 11);
    chk("game_over", game_over, int'(lives_m == 0));
    if (exp_hit && lives_m != 0) begin
      ic = 2; hc2 = 0;
      for (int j = 0; j < 40; j++) begin
        frame_start = (j < 8 && j % 2 == 0);
        @(posedge clk); #1;
        frame_start = 1'b0;
        if (hit) hc2++;
        if (!invuln) break;
        ic++;
      end
      frame_start = 1'b0;
      chk("invuln_len", ic, INV);
      chk("hit_in_invuln", hc2, 0);
    end else if (exp_hit) begin
      repeat (3) @(posedge clk);
      #1 chk("game_over_hold", game_over, 1);
      start_game = 1'b0;
      @(posedge clk); #1;
      chk("restart_lives", lives, 3);
      chk("restart_game_over", game_over, 0);
      start_game = 1'b1;
      @(posedge clk); #1;
      lives_m = 3;
    end
  endtask

  task automatic abort_scan(input bit use_rst);
    int hc;
    clear_scene(100, 500);
    smask = 1 << 3; sbx[3] = 120; sby[3] = 520;
    drive_scene();
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    repeat (4) @(posedge clk);
    @(posedge clk);
    hc = 0;
    if (use_rst) begin
      rst = 1'b0;
      #1;
      chk("rst_lives", lives, 3);
      chk("rst_hit", hit, 0);
      chk("rst_invuln", invuln, 0);
      @(posedge clk); #1;
      rst = 1'b1;
    end else begin
      #1 start_game = 1'b0;
    end
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (hit) hc++;
    end
    chk(use_rst ? "rst_no_hit" : "abort_no_hit", hc, 0);
    chk(use_rst ? "rst_lives_after" : "abort_lives", lives, 3);
    if (!use_rst) begin
      start_game = 1'b1;
      @(posedge clk); #1;
    end
    lives_m = 3;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_lives", lives, 3);
    chk("reset_hit", hit, 0);
    chk("reset_game_over", game_over, 0);
    chk("reset_invuln", invuln, 0);
    chk("reset_hit_idx", hit_idx, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("idle_lives", lives, 3);
    start_game = 1'b1;
    @(posedge clk); #1;

    // single hit on slot 3
    clear_scene(100, 500);
    smask = 1 << 3; sbx[3] = 120; sby[3] = 520;
    run_scan(1'b0);

    // edge touches and an inactive overlapping slot
    clear_scene(100, 500);
    smask = 32'h5;
    sbx[0] = 148; sby[0] = 500;
    sbx[1] = 110; sby[1] = 510;
    sbx[2] = 100; sby[2] = 564;
    run_scan(1'b0);

    // animation blocks the scan
    clear_scene(100, 500);
    smask = 1; sbx[0] = 100; sby[0] = 500;
    run_scan(1'b1);

    // two colliding slots cost one life
    clear_scene(100, 500);
    smask = (1 << 2) | (1 << 7);
    sbx[2] = 90; sby[2] = 540; sbx[7] = 130; sby[7] = 480;
    run_scan(1'b0);

    // far corner, sums must not wrap; third hit ends the game
    clear_scene(2000, 2000);
    smask = 1 << 9; sbx[9] = 2040; sby[9] = 2040;
    run_scan(1'b0);

    abort_scan(1'b1);
    abort_scan(1'b0);

    for (int n = 0; n < 40; n++) begin
      random_scene();
      run_scan($urandom_range(0, 7) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
